// File: rtl/toggle_gen.sv
// Burst generator for a downstream t_ff: issues `num` one-cycle t pulses spaced
// div+1 clocks apart, with busy/left status and a one-cycle done strobe.
module toggle_gen #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         restn,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] div,
    input  logic [W-1:0] num,
    output logic         t,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] left
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t       state, state_n;
    logic [W-1:0] cnt, cnt_n;
    logic [W-1:0] div_q, div_n;
    logic [W-1:0] num_q, num_n;
    logic [W-1:0] sent, sent_n;
    logic         fire;
    logic         busy_n, done_n;
    logic [W-1:0] left_n;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        div_n   = div_q;
        num_n   = num_q;
        sent_n  = sent;
        fire    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    div_n  = div;
                    num_n  = num;
                    sent_n = '0;
                    cnt_n  = '0;
                    if (num == '0) begin
                        state_n = DONE;
                    end else begin
                        state_n = RUN;
                        // The accept edge is the first spacing tick: div=0 pulses
                        // at once, otherwise counting resumes from 1.
                        if (div == '0) begin
                            fire   = 1'b1;
                            sent_n = W'(1);
                        end else begin
                            cnt_n = W'(1);
                        end
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (sent == num_q) begin
                    state_n = DONE;
                end else if (cnt == div_q) begin
                    fire   = 1'b1;
                    cnt_n  = '0;
                    sent_n = sent + W'(1);
                end else begin
                    cnt_n = cnt + W'(1);
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        busy_n = (state_n == RUN);
        done_n = (state_n == DONE);
        left_n = (state_n == RUN) ? (num_n - sent_n) : '0;
    end

    always_ff @(posedge clk or posedge restn) begin
        if (restn) begin
            state <= IDLE;
            cnt   <= '0;
            div_q <= '0;
            num_q <= '0;
            sent  <= '0;
            t     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            left  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            div_q <= div_n;
            num_q <= num_n;
            sent  <= sent_n;
            t     <= fire;
            busy  <= busy_n;
            done  <= done_n;
            left  <= left_n;
        end
    end

endmodule

// File: tb/tb_toggle_gen.sv
// Directed bench for toggle_gen: a schedule-based burst model checked every cycle,
// plus literal expectations and a behavioural t_ff on the t output.
module tb_toggle_gen;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         restn = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] div = '0;
    logic [W-1:0] num = '0;
    logic         t, busy, done;
    logic [W-1:0] left;

    int n_pass = 0;
    int n_chk  = 0;
    int cur    = 0;

    toggle_gen #(.W(W)) dut (
        .clk(clk), .restn(restn), .start(start), .abort(abort),
        .div(div), .num(num), .t(t), .busy(busy), .done(done), .left(left)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (time %0t)", name, act, exp, $time);
    endtask

    // Burst model: expected outputs depend only on cycles elapsed since accept.
    bit m_active = 1'b0;
    int m_c = 0, m_div = 0, m_num = 0, m_n = 0;

    always @(posedge clk or posedge restn) begin
        if (restn) begin
            m_active <= 1'b0;
        end else begin
            automatic bit idle = !m_active || (m_c >= m_n + 2);
            if (m_active && m_c >= 1 && m_c <= m_n && abort) begin
                m_active <= 1'b0;
            end else if (idle && start) begin
                m_active <= 1'b1;
                m_c   <= 1;
                m_div <= int'(div);
                m_num <= int'(num);
                m_n   <= int'(num) * (int'(div) + 1);
            end else if (m_active && m_c < m_n + 2) begin
                m_c <= m_c + 1;
            end
        end
    end

    always @(negedge clk) begin
        automatic int e_t = 0, e_busy = 0, e_done = 0, e_left = 0;
        if (m_active && m_c >= 1 && m_c <= m_n) begin
            e_t    = (m_c % (m_div + 1) == 0) ? 1 : 0;
            e_busy = 1;
            e_left = m_num - m_c / (m_div + 1);
        end else if (m_active && m_c == m_n + 1) begin
            e_done = 1;
        end
        check("model_t", int'(t), e_t);
        check("model_busy", int'(busy), e_busy);
        check("model_done", int'(done), e_done);
        check("model_left", int'(left), e_left);
    end

    // Downstream t_ff driven by t.
    logic q;
    int   tog;
    always @(posedge clk or posedge restn) begin
        if (restn) begin
            q   <= 1'b0;
            tog <= 0;
        end else if (t) begin
            q   <= ~q;
            tog <= tog + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input int d, input int n);
        div   = W'(d);
        num   = W'(n);
        start = 1'b1;
        step();
        start = 1'b0;
        cur   = 1;
    endtask

    task automatic cyc_to(input int k);
        while (cur < k) begin
            step();
            cur++;
        end
    endtask

    initial begin
        step();
        step();
        check("rst_t", int'(t), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_left", int'(left), 0);
        restn = 1'b0;
        step();

        // div=2 num=3, inputs disturbed mid-burst
        go(2, 3);
        check("b1_c1_left", int'(left), 3);
        check("b1_c1_busy", int'(busy), 1);
        check("b1_c1_t", int'(t), 0);
        cyc_to(2);
        start = 1'b1; div = 8'd7; num = 8'd9;
        cyc_to(3);
        start = 1'b0;
        check("b1_c3_t", int'(t), 1);
        cyc_to(4);
        check("b1_c4_t", int'(t), 0);
        cyc_to(6);
        check("b1_c6_t", int'(t), 1);
        cyc_to(9);
        check("b1_c9_t", int'(t), 1);
        check("b1_c9_busy", int'(busy), 1);
        check("b1_c9_left", int'(left), 0);
        cyc_to(10);
        check("b1_c10_done", int'(done), 1);
        check("b1_c10_busy", int'(busy), 0);
        cyc_to(11);
        check("b1_c11_done", int'(done), 0);

        // back-to-back: div=0 num=4
        go(0, 4);
        check("b2_c1_t", int'(t), 1);
        check("b2_c1_left", int'(left), 3);
        cyc_to(2);
        check("b2_c2_left", int'(left), 2);
        cyc_to(3);
        check("b2_c3_left", int'(left), 1);
        cyc_to(4);
        check("b2_c4_t", int'(t), 1);
        check("b2_c4_left", int'(left), 0);
        cyc_to(5);
        check("b2_c5_done", int'(done), 1);
        check("b2_c5_t", int'(t), 0);
        cyc_to(6);

        // abort in IDLE is a no-op
        abort = 1'b1;
        step();
        step();
        abort = 1'b0;
        check("idle_abort_busy", int'(busy), 0);

        // num=0
        go(5, 0);
        check("b3_c1_done", int'(done), 1);
        check("b3_c1_busy", int'(busy), 0);
        cyc_to(2);
        check("b3_c2_done", int'(done), 0);

        // div=3 num=5 aborted after the 2nd pulse
        go(3, 5);
        cyc_to(8);
        check("b4_c8_t", int'(t), 1);
        cyc_to(9);
        abort = 1'b1;
        cyc_to(10);
        abort = 1'b0;
        check("b4_c10_busy", int'(busy), 0);
        check("b4_c10_left", int'(left), 0);
        check("b4_c10_t", int'(t), 0);
        cyc_to(12);
        check("b4_c12_done", int'(done), 0);

        // abort coinciding with the final-pulse cycle
        go(1, 2);
        cyc_to(4);
        check("b5_c4_t", int'(t), 1);
        abort = 1'b1;
        cyc_to(5);
        abort = 1'b0;
        check("b5_c5_done", int'(done), 0);
        check("b5_c5_busy", int'(busy), 0);
        cyc_to(7);

        // asynchronous reset mid-burst
        go(2, 3);
        cyc_to(3);
        #3;
        restn = 1'b1;
        #1;
        check("arst_t", int'(t), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_left", int'(left), 0);
        step();
        restn = 1'b0;
        step();
        go(1, 2);
        cyc_to(2);
        check("b6_c2_t", int'(t), 1);
        cyc_to(3);
        check("b6_c3_t", int'(t), 0);
        cyc_to(4);
        check("b6_c4_t", int'(t), 1);
        cyc_to(5);
        check("b6_c5_done", int'(done), 1);
        cyc_to(6);

        // t_ff driven through a 4-pulse burst
        restn = 1'b1;
        step();
        restn = 1'b0;
        step();
        go(1, 4);
        cyc_to(10);
        check("tff_toggles", tog, 4);
        check("tff_q", int'(q), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
